tt_print_ctl: RTL and testbench
===============================

# tt_print_ctl

Print sequencer for the console typewriter. It accepts EBCDIC characters over a valid/ready handshake and presents each character to the downstream EBCDIC-to-typewriter translator, waiting out the translator's latency. From the tilt/rotate code and case flags that come back, it issues timed mechanical strobes: print, shift-up, shift-down, space and carrier return. It sits between the channel/console data register and the typewriter magnet drivers, and it is the only block that drives the translator input.

## Interface
Parameters:
- XLATE_LAT, 3, translator latency in cycles from data change to valid code/flags
- STROBE_CYC, 4, magnet strobe high time in cycles (>=1)
- SETTLE_CYC, 16, mechanical settle time after print/space/shift strobe (>=0)
- CR_SETTLE_CYC, 64, settle time after carrier-return strobe
- LINE_LEN, 80, columns per line (used only with TT_AUTO_CR_EN)

Ports:
- i_clk  in  1  clock; the block uses this single clock
- i_reset  in  1  reset, synchronous and active-high
- i_char  in  8  EBCDIC character
- i_char_valid  in  1  character offered
- o_char_ready  out  1  controller can accept a character
- o_data_reg  out  8  character driven to the translator
- i_tt_code  in  6  translator tilt/rotate code
- i_lower_case_character  in  1  translator: character requires lower case
- i_upper_case_character  in  1  translator: character requires upper case
- o_tt_sel  out  6  latched code presented to the print magnets
- o_print, o_space, o_cr, o_shift_up, o_shift_down  out  1 each  magnet strobes
- o_case_upper  out  1  current carriage case (1 = upper)
- o_unprintable  out  1  one-cycle pulse when a character is dropped

## Operation
- States: INIT, IDLE, XLATE, SHIFT, SHIFT_SETTLE, OP, OP_SETTLE.
- Reset:
  - All strobes, o_unprintable, o_char_ready, o_tt_sel and o_data_reg are forced to 0.
  - o_case_upper is forced to 0.
  - The state goes to INIT.
- INIT:
  - o_shift_down pulses for STROBE_CYC cycles, followed by SETTLE_CYC idle cycles. This puts the mechanism in a known lower-case position.
  - The state then goes to IDLE.
- IDLE:
  - o_char_ready is 1.
  - When i_char_valid and o_char_ready are both high at an edge, i_char is latched into o_data_reg, o_char_ready drops and the state goes to XLATE.
- XLATE:
  - Waits XLATE_LAT cycles.
  - At the last edge, i_tt_code is latched into o_tt_sel, and the flags are sampled.
- Dispatch, evaluated in this order:
  - 0x15 (NL) → CR operation.
  - 0x40 (SP) → SPACE operation.
  - Case flag differs from o_case_upper → SHIFT, then PRINT.
  - Either case flag set and case already matches → PRINT.
  - Neither flag set and i_tt_code nonzero → PRINT with no shift (case-independent character).
  - Anything else → o_unprintable pulses for 1 cycle and the state returns to IDLE.
- If both case flags are set at once, upper takes priority.
- SHIFT:
  - The strobe is o_shift_up or o_shift_down, as required.
  - o_case_upper toggles on the edge the strobe falls.
- Each operation holds its strobe for STROBE_CYC cycles and then waits its settle time. CR uses CR_SETTLE_CYC; every other operation uses SETTLE_CYC.
- At most one strobe is high in any cycle.
- o_data_reg and o_tt_sel hold their values until the next character is accepted.
- i_reset in any state aborts the operation in the same edge. Strobes drop immediately, and INIT re-runs.

## Timing
Let A be the acceptance edge.
- Translator sample edge: A+XLATE_LAT.
- First operation strobe rises at A+XLATE_LAT+1 and is high for STROBE_CYC cycles.
- Plain print: o_char_ready returns high at A+XLATE_LAT+1+STROBE_CYC+SETTLE_CYC. With defaults this is A+24.
- Shifted print: adds STROBE_CYC+SETTLE_CYC before the print strobe. With defaults, the print strobe rises at A+24 and ready returns at A+44.
- CR: ready returns at A+XLATE_LAT+1+STROBE_CYC+CR_SETTLE_CYC, which is A+72 with defaults.
- Unprintable: the o_unprintable pulse occurs in cycle A+XLATE_LAT+1, and ready returns the following cycle.
- After i_reset deasserts, o_char_ready rises after STROBE_CYC+SETTLE_CYC+1 cycles, which is 21 cycles with defaults.
- i_char is ignored while o_char_ready is low.

## Configuration
- The feature macro is TT_AUTO_CR_EN.
- When defined, a column counter is added:
  - It increments on every PRINT and SPACE operation.
  - It resets to 0 on CR and on reset.
  - When the counter reaches LINE_LEN, a CR operation is inserted before the next PRINT or SPACE. This happens after translation and before any shift.
- When not defined:
  - There is no counter.
  - CR is issued only for 0x15.

## Structure
- The shared package holds:
  - the state enum
  - EBCDIC constants NL=8'h15 and SP=8'h40
  - the default timing constants
- Sub-module tt_strobe_timer: a loadable down-counter producing strobe-high and settle phases and a done pulse. It is reused for the INIT, SHIFT and OP phases.
- The translator is instantiated outside the block and is not part of it.

## Test plan
- Reset release → o_shift_down high for cycles 1–4, o_char_ready rises at cycle 21, o_case_upper=0.
- 0x81 (lower-case 'a') → o_print rises at A+4 for 4 cycles, no shift strobe, ready returns at A+24.
- 0xC1 ('A') then 0x81 → shift-up precedes the first print and o_case_upper=1; shift-down precedes the second print.
- 0x15 → o_cr for 4 cycles, ready returns at A+72; 0x40 → o_space only.
- 0x00 (code 0, no flags) → o_unprintable single pulse, no strobe.
- Reset asserted mid-print strobe → strobe low on the next edge, INIT sequence repeats. With TT_AUTO_CR_EN and LINE_LEN=3, the 4th 0x81 is preceded by o_cr.

Source files
------------

// File: rtl/tt_print_ctl_pkg.sv
// Shared types and constants for the console typewriter print sequencer.
package tt_print_ctl_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    INIT, IDLE, XLATE, SHIFT, SHIFT_SETTLE, OP, OP_SETTLE
  } state_t;

  // The magnet strobe that the active timer phase drives.
  typedef enum logic [2:0] {
    K_NONE, K_PRINT, K_SPACE, K_CR, K_UP, K_DOWN
  } kind_t;

  // Dispatch decision taken once the translator result is available.
  typedef enum logic [2:0] {
    D_CR, D_SPACE, D_UP, D_DOWN, D_PRINT, D_DROP
  } disp_t;

  // Phases of the strobe timer.
  typedef enum logic [1:0] {
    PH_IDLE, PH_STROBE, PH_SETTLE
  } phase_t;

  localparam logic [7:0] EBCDIC_NL = 8'h15;
  localparam logic [7:0] EBCDIC_SP = 8'h40;

  localparam int DEF_XLATE_LAT     = 3;
  localparam int DEF_STROBE_CYC    = 4;
  localparam int DEF_SETTLE_CYC    = 16;
  localparam int DEF_CR_SETTLE_CYC = 64;
  localparam int DEF_LINE_LEN      = 80;

  // Width of the strobe timer's counter and length inputs.
  localparam int TW = 16;

  // Chooses the mechanical operation for a translated character.
  // The upper flag wins when both case flags are set.
  function automatic disp_t classify(input logic [7:0] ch,
                                     input logic       upper,
                                     input logic       lower,
                                     input logic [5:0] code,
                                     input logic       case_upper);
    disp_t d;
    if (ch == EBCDIC_NL)           d = D_CR;
    else if (ch == EBCDIC_SP)      d = D_SPACE;
    else if (upper || lower) begin
      if (upper != case_upper)     d = upper ? D_UP : D_DOWN;
      else                         d = D_PRINT;
    end
    else if (code != '0)           d = D_PRINT;
    else                           d = D_DROP;
    return d;
  endfunction

endpackage

// File: rtl/tt_print_ctl_if.sv
// Character handshake between the console data register and the print sequencer.
interface tt_print_ctl_if;
  logic [7:0] i_char;
  logic       i_char_valid;
  logic       o_char_ready;

  modport master (output i_char, output i_char_valid, input o_char_ready);
  modport slave  (input i_char, input i_char_valid, output o_char_ready);
endinterface

// File: rtl/tt_print_ctl_timer.sv
// tt_strobe_timer: loadable down-counter giving a strobe-high phase followed by
// a settle phase. strobe_end_o marks the last strobe cycle, done_o the last
// cycle of the whole operation (settle of zero makes them coincide).
module tt_strobe_timer
  import tt_print_ctl_pkg::*;
(
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          load_i,
  input  logic [TW-1:0] strobe_len_i,
  input  logic [TW-1:0] settle_len_i,
  output logic          strobe_o,
  output logic          strobe_end_o,
  output logic          busy_o,
  output logic          done_o
);

  phase_t        phase_q, phase_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] settle_q, settle_d;

  // Phase sequencing; a load restarts the strobe phase unconditionally.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    settle_d     = settle_q;
    strobe_end_o = (phase_q == PH_STROBE) && (cnt_q == TW'(1));
    done_o       = (strobe_end_o && (settle_q == '0)) ||
                   ((phase_q == PH_SETTLE) && (cnt_q == TW'(1)));
    if (load_i) begin
      phase_d  = PH_STROBE;
      cnt_d    = strobe_len_i;
      settle_d = settle_len_i;
    end else if (strobe_end_o) begin
      if (settle_q == '0) begin
        phase_d = PH_IDLE;
      end else begin
        phase_d = PH_SETTLE;
        cnt_d   = settle_q;
      end
    end else if (phase_q == PH_SETTLE) begin
      if (cnt_q == TW'(1)) phase_d = PH_IDLE;
      else                 cnt_d   = cnt_q - TW'(1);
    end else if (phase_q == PH_STROBE) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  // Timer state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (reset_i) begin
      phase_q  <= PH_IDLE;
      cnt_q    <= '0;
      settle_q <= '0;
    end else begin
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
    end
  end

  assign strobe_o = (phase_q == PH_STROBE);
  assign busy_o   = (phase_q != PH_IDLE);

endmodule

// File: rtl/tt_print_ctl.sv
// tt_print_ctl: console typewriter print sequencer. Accepts EBCDIC characters,
// waits out the external translator and issues timed magnet strobes.
// Optional feature macro TT_AUTO_CR_EN adds a column counter that inserts a
// carrier return once LINE_LEN columns have been printed.
module tt_print_ctl
  import tt_print_ctl_pkg::*;
#(
  parameter int XLATE_LAT     = DEF_XLATE_LAT,   // >= 1
  parameter int STROBE_CYC    = DEF_STROBE_CYC,
  parameter int SETTLE_CYC    = DEF_SETTLE_CYC,
  parameter int CR_SETTLE_CYC = DEF_CR_SETTLE_CYC,
  parameter int LINE_LEN      = DEF_LINE_LEN
) (
  input  logic           i_clk,
  input  logic           i_reset,
  tt_print_ctl_if.slave  chan,
  output logic [7:0]     o_data_reg,
  input  logic [5:0]     i_tt_code,
  input  logic           i_lower_case_character,
  input  logic           i_upper_case_character,
  output logic [5:0]     o_tt_sel,
  output logic           o_print,
  output logic           o_space,
  output logic           o_cr,
  output logic           o_shift_up,
  output logic           o_shift_down,
  output logic           o_case_upper,
  output logic           o_unprintable
);

  state_t        state_q, state_d;
  kind_t         kind_q, kind_d;
  logic [7:0]    xcnt_q, xcnt_d;
  logic [7:0]    data_q, data_d;
  logic [5:0]    sel_q, sel_d;
  logic          upper_q, upper_d, lower_q, lower_d;
  logic          case_q, case_d;
  logic          ready_q, ready_d;
  logic          unp_q, unp_d;

  logic          t_load, t_strobe, t_end, t_busy, t_done;
  logic [TW-1:0] t_settle;
  logic          go, do_print, finish;
  logic          need_cr, resume_q;
  disp_t         disp;

  assign disp = classify(data_q, upper_q, lower_q, sel_q, case_q);

  tt_strobe_timer u_timer (
    .clk_i        (i_clk),
    .reset_i      (i_reset),
    .load_i       (t_load),
    .strobe_len_i (TW'(STROBE_CYC)),
    .settle_len_i (t_settle),
    .strobe_o     (t_strobe),
    .strobe_end_o (t_end),
    .busy_o       (t_busy),
    .done_o       (t_done)
  );

  // Sequencer next-state, timer loads and dispatch of translated characters.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    xcnt_d   = xcnt_q;
    data_d   = data_q;
    sel_d    = sel_q;
    upper_d  = upper_q;
    lower_d  = lower_q;
    case_d   = case_q;
    unp_d    = 1'b0;
    t_load   = 1'b0;
    t_settle = TW'(SETTLE_CYC);
    go       = 1'b0;
    do_print = 1'b0;
    finish   = 1'b0;

    case (state_q)
      INIT: begin
        // Drive the carriage to lower case before accepting characters.
        if (!t_busy) begin
          t_load = 1'b1;
          kind_d = K_DOWN;
        end else if (t_done) begin
          state_d = IDLE;
          kind_d  = K_NONE;
        end
      end
      IDLE: begin
        if (chan.i_char_valid && ready_q) begin
          data_d  = chan.i_char;
          xcnt_d  = '0;
          state_d = XLATE;
        end
      end
      XLATE: begin
        xcnt_d = xcnt_q + 8'd1;
        if (xcnt_q == 8'(XLATE_LAT - 1)) begin
          sel_d   = i_tt_code;
          upper_d = i_upper_case_character;
          lower_d = i_lower_case_character;
        end
        if (xcnt_q == 8'(XLATE_LAT)) go = 1'b1;
      end
      SHIFT: begin
        if (t_end) case_d = ~case_q;
        if (t_done)     do_print = 1'b1;
        else if (t_end) state_d  = SHIFT_SETTLE;
      end
      SHIFT_SETTLE: if (t_done) do_print = 1'b1;
      OP: begin
        if (t_done)     finish  = 1'b1;
        else if (t_end) state_d = OP_SETTLE;
      end
      OP_SETTLE: if (t_done) finish = 1'b1;
      default: state_d = INIT;
    endcase

    // An inserted carrier return resumes the pending character afterwards.
    if (finish) begin
      if (resume_q) begin
        go = 1'b1;
      end else begin
        state_d = IDLE;
        kind_d  = K_NONE;
      end
    end

    if (go) begin
      t_load  = 1'b1;
      state_d = OP;
      if (need_cr) begin
        kind_d   = K_CR;
        t_settle = TW'(CR_SETTLE_CYC);
      end else begin
        case (disp)
          D_CR: begin
            kind_d   = K_CR;
            t_settle = TW'(CR_SETTLE_CYC);
          end
          D_SPACE: kind_d   = K_SPACE;
          D_UP:    begin kind_d = K_UP;   state_d = SHIFT; end
          D_DOWN:  begin kind_d = K_DOWN; state_d = SHIFT; end
          D_PRINT: do_print = 1'b1;
          default: begin
            t_load  = 1'b0;
            state_d = IDLE;
            kind_d  = K_NONE;
            unp_d   = 1'b1;
          end
        endcase
      end
    end

    if (do_print) begin
      t_load  = 1'b1;
      state_d = OP;
      kind_d  = K_PRINT;
    end

    // Ready follows the drop pulse by one cycle.
    ready_d = (state_d == IDLE) && !unp_d;
  end

  // Sequencer registers; reset aborts any operation and re-runs INIT.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= INIT;
      kind_q  <= K_NONE;
      xcnt_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      upper_q <= 1'b0;
      lower_q <= 1'b0;
      case_q  <= 1'b0;
      ready_q <= 1'b0;
      unp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      xcnt_q  <= xcnt_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      upper_q <= upper_d;
      lower_q <= lower_d;
      case_q  <= case_d;
      ready_q <= ready_d;
      unp_q   <= unp_d;
    end
  end

`ifdef TT_AUTO_CR_EN
  logic [15:0] col_q, col_d;
  logic        resume_d;

  assign need_cr = (col_q >= 16'(LINE_LEN)) &&
                   (disp inside {D_SPACE, D_PRINT, D_UP, D_DOWN});

  // Column count and pending-character flag for automatic carrier return.
  always_comb begin
    col_d    = col_q;
    resume_d = go ? need_cr : resume_q;
    if (t_load && (kind_d == K_CR))                              col_d = '0;
    else if (t_load && ((kind_d == K_PRINT) || (kind_d == K_SPACE))) col_d = col_q + 16'd1;
  end

  // Column counter registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      col_q    <= '0;
      resume_q <= 1'b0;
    end else begin
      col_q    <= col_d;
      resume_q <= resume_d;
    end
  end
`else
  assign need_cr  = 1'b0;
  assign resume_q = 1'b0;
`endif

  assign chan.o_char_ready = ready_q;
  assign o_data_reg        = data_q;
  assign o_tt_sel          = sel_q;
  assign o_case_upper      = case_q;
  assign o_unprintable     = unp_q;
  assign o_print           = t_strobe && (kind_q == K_PRINT);
  assign o_space           = t_strobe && (kind_q == K_SPACE);
  assign o_cr              = t_strobe && (kind_q == K_CR);
  assign o_shift_up        = t_strobe && (kind_q == K_UP);
  assign o_shift_down      = t_strobe && (kind_q == K_DOWN);

endmodule

// File: tb/tb_tt_print_ctl.sv
// Self-checking bench for tt_print_ctl with a 3-cycle translator model.
module tb_tt_print_ctl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tt_print_ctl_if chan();

  logic [7:0] data_reg;
  logic [5:0] tt_code, tt_sel;
  logic       up_f, lo_f;
  logic       print, space, cr, sup, sdn, case_upper, unp;
  logic [7:0] s1 = '0, s2 = '0;

  tt_print_ctl #(
    .XLATE_LAT(3), .STROBE_CYC(4), .SETTLE_CYC(16), .CR_SETTLE_CYC(64), .LINE_LEN(3)
  ) dut (
    .i_clk                  (clk),
    .i_reset                (rst),
    .chan                   (chan),
    .o_data_reg             (data_reg),
    .i_tt_code              (tt_code),
    .i_lower_case_character (lo_f),
    .i_upper_case_character (up_f),
    .o_tt_sel               (tt_sel),
    .o_print                (print),
    .o_space                (space),
    .o_cr                   (cr),
    .o_shift_up             (sup),
    .o_shift_down           (sdn),
    .o_case_upper           (case_upper),
    .o_unprintable          (unp)
  );

  // Translator model: {upper, lower, code}.
  function automatic logic [7:0] lut(input logic [7:0] ch);
    case (ch)
      8'h81:   return {2'b01, 6'h05};
      8'hC1:   return {2'b10, 6'h05};
      8'h4B:   return {2'b00, 6'h12};
      8'h7F:   return {2'b11, 6'h21};
      default: return 8'h00;
    endcase
  endfunction

  // Result is stable from two edges after a data change, sampled on the third.
  always @(posedge clk) begin
    s1 <= lut(data_reg);
    s2 <= s1;
  end
  assign {up_f, lo_f, tt_code} = s2;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-character record: index 0 print, 1 space, 2 cr, 3 up, 4 down.
  int rec_first[5];
  int rec_cnt[5];
  int unp_first, unp_cnt, rdy_at, chg_at, overlap;

  // Offer one character at a negedge and record outputs per cycle after the
  // acceptance edge A until ready returns. i_char is garbage while busy.
  task automatic run_char(input logic [7:0] ch);
    logic [4:0] s;
    logic       case0;
    for (int i = 0; i < 5; i++) begin rec_first[i] = -1; rec_cnt[i] = 0; end
    unp_first = -1; unp_cnt = 0; rdy_at = -1; chg_at = -1; overlap = 0;
    case0 = case_upper;
    chan.i_char = ch;
    chan.i_char_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chan.i_char = 8'hFF;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk);
      @(negedge clk);
      s = {sdn, sup, cr, space, print};
      for (int i = 0; i < 5; i++)
        if (s[i]) begin
          rec_cnt[i]++;
          if (rec_first[i] < 0) rec_first[i] = k;
        end
      if ($countones(s) > 1) overlap++;
      if (unp) begin unp_cnt++; if (unp_first < 0) unp_first = k; end
      if (case_upper != case0 && chg_at < 0) chg_at = k;
      if (chan.o_char_ready) begin rdy_at = k; break; end
    end
    chan.i_char_valid = 1'b0;
  endtask

  // Called at the negedge reset is released; checks the INIT sequence.
  task automatic init_check(input string tag);
    int sd_first = -1, sd_cnt = 0, others = 0, rdy = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (sdn) begin sd_cnt++; if (sd_first < 0) sd_first = k; end
      others += int'(print) + int'(space) + int'(cr) + int'(sup) + int'(unp);
      if (chan.o_char_ready) begin rdy = k; break; end
    end
    check({tag, " shift_down first"}, sd_first, 1);
    check({tag, " shift_down cycles"}, sd_cnt, 4);
    check({tag, " other strobes"}, others, 0);
    check({tag, " ready cycle"}, rdy, 21);
    check({tag, " case_upper"}, int'(case_upper), 0);
  endtask

  typedef struct {
    logic [7:0] ch;
    int         op;      // 0 print, 1 space, 2 cr, 3 dropped
    int         shift;   // 0 none, 1 up, 2 down
    int         sel;
    int         ready;
    int         case_after;
  } vec_t;

  vec_t vecs[10];
  vec_t t;
  int   op_at, other;

  initial begin
    vecs[0] = '{8'h81, 0, 0, 'h05, 24, 0};
    vecs[1] = '{8'hC1, 0, 1, 'h05, 44, 1};
    vecs[2] = '{8'h81, 0, 2, 'h05, 44, 0};
    vecs[3] = '{8'h15, 2, 0, 'h00, 72, 0};
    vecs[4] = '{8'h40, 1, 0, 'h00, 24, 0};
    vecs[5] = '{8'h00, 3, 0, 'h00,  5, 0};
    vecs[6] = '{8'h4B, 0, 0, 'h12, 24, 0};
    vecs[7] = '{8'h15, 2, 0, 'h00, 72, 0};
    vecs[8] = '{8'h7F, 0, 1, 'h21, 44, 1};
    vecs[9] = '{8'h4B, 0, 0, 'h12, 24, 1};

    rst = 1'b1;
    chan.i_char = 8'h00;
    chan.i_char_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset strobes", int'({print, space, cr, sup, sdn, unp}), 0);
    check("reset ready", int'(chan.o_char_ready), 0);
    check("reset data_reg", int'(data_reg), 0);
    check("reset tt_sel", int'(tt_sel), 0);
    check("reset case_upper", int'(case_upper), 0);
    rst = 1'b0;
    init_check("init");

    for (int v = 0; v < 10; v++) begin
      t = vecs[v];
      run_char(t.ch);
      op_at = (t.shift != 0) ? 24 : 4;
      if (t.op < 3) begin
        check($sformatf("v%0d op first", v), rec_first[t.op], op_at);
        check($sformatf("v%0d op cycles", v), rec_cnt[t.op], 4);
      end
      other = 0;
      for (int i = 0; i < 3; i++) if (i != t.op) other += rec_cnt[i];
      check($sformatf("v%0d other op strobes", v), other, 0);
      check($sformatf("v%0d shift_up cycles", v), rec_cnt[3], (t.shift == 1) ? 4 : 0);
      check($sformatf("v%0d shift_up first", v), rec_first[3], (t.shift == 1) ? 4 : -1);
      check($sformatf("v%0d shift_down cycles", v), rec_cnt[4], (t.shift == 2) ? 4 : 0);
      check($sformatf("v%0d shift_down first", v), rec_first[4], (t.shift == 2) ? 4 : -1);
      check($sformatf("v%0d unprintable cycles", v), unp_cnt, (t.op == 3) ? 1 : 0);
      check($sformatf("v%0d unprintable first", v), unp_first, (t.op == 3) ? 4 : -1);
      check($sformatf("v%0d ready cycle", v), rdy_at, t.ready);
      check($sformatf("v%0d case_upper", v), int'(case_upper), t.case_after);
      check($sformatf("v%0d case change cycle", v), chg_at, (t.shift != 0) ? 8 : -1);
      check($sformatf("v%0d tt_sel", v), int'(tt_sel), t.sel);
      check($sformatf("v%0d data_reg", v), int'(data_reg), int'(t.ch));
      check($sformatf("v%0d strobe overlap", v), overlap, 0);
    end

    // Reset in the middle of a print strobe while the carriage is in upper case.
    chan.i_char = 8'h4B;
    chan.i_char_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chan.i_char_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mid print high", int'(print), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset print drop", int'(print), 0);
    check("reset ready drop", int'(chan.o_char_ready), 0);
    check("reset case drop", int'(case_upper), 0);
    check("reset data_reg clear", int'(data_reg), 0);
    @(negedge clk);
    rst = 1'b0;
    init_check("reinit");

    // Three plain prints, then a fourth that meets the line limit.
    for (int n = 0; n < 3; n++) begin
      run_char(8'h81);
      check($sformatf("col%0d print first", n), rec_first[0], 4);
      check($sformatf("col%0d ready cycle", n), rdy_at, 24);
    end
    run_char(8'h81);
`ifdef TT_AUTO_CR_EN
    check("auto cr first", rec_first[2], 4);
    check("auto cr cycles", rec_cnt[2], 4);
    check("auto print first", rec_first[0], 72);
    check("auto ready cycle", rdy_at, 92);
`else
    check("no auto cr", rec_cnt[2], 0);
    check("fourth print first", rec_first[0], 4);
    check("fourth ready cycle", rdy_at, 24);
`endif
    check("fourth strobe overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
